aes_round_pipe: RTL and testbench

- Parametrised AES-128 encryption round unit: SubBytes -> ShiftRows -> optional MixColumns -> AddRoundKey.
- A per-beat mode bit selects a normal round (with MixColumns) or the final round (MixColumns bypassed), so one block replaces separate middle- and last-round instances.
- Adds a valid/ready handshake with backpressure, a configurable pipeline depth, an async reset and a sideband tag carried alongside the data.
- Instantiated N times in the unrolled encryptor, or once in an iterative core.

---
 rtl/aes_round_pipe.sv | 152 +++++++++++++++
 tb/tb_aes_round_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_pipe.sv
// One AES-128 encryption round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey)
// behind a valid/ready handshake, with a 1- or 2-stage pipeline and a sideband tag.

module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   // byte 0 of the table sits in the top bits, so index downward from 2047
   assign y = SBOX_TABLE[11'd2047 - {a, 3'b000} -: 8];
endmodule

module shift_rows (
   input  logic [127:0] d,
   output logic [127:0] q
);
   // byte index is row + 4*column; row r rotates left by r columns
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign q[127 - 8*(r + 4*c) -: 8] = d[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
   end
endmodule

module aes_round_pipe #(
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [127:0]     in_data,
   input  logic [127:0]     in_key,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [TAG_W-1:0] out_tag
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [7:0] a0, a1, a2, a3;
      mix_columns = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         mix_columns[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mix_columns[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mix_columns[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mix_columns[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   endfunction

   logic             adv_s;
   logic [127:0]     sub_s;
   logic [127:0]     shift_s;
   logic             mid_valid_s;
   logic             mid_last_s;
   logic [127:0]     mid_data_s;
   logic [127:0]     mid_key_s;
   logic [TAG_W-1:0] mid_tag_s;
   logic [127:0]     round_s;
   logic             out_valid_r;
   logic [127:0]     out_data_r;
   logic [TAG_W-1:0] out_tag_r;

   // one global enable: the whole pipe moves unless a held output is blocked
   assign adv_s    = ~out_valid_r | out_ready;
   assign in_ready = adv_s;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      sbox u_sbox (.a(in_data[127 - 8*i -: 8]), .y(sub_s[127 - 8*i -: 8]));
   end

   shift_rows u_shift_rows (.d(sub_s), .q(shift_s));

   if (PIPE_STAGES == 1) begin : g_one
      assign mid_valid_s = in_valid;
      assign mid_last_s  = in_last;
      assign mid_data_s  = shift_s;
      assign mid_key_s   = in_key;
      assign mid_tag_s   = in_tag;
   end else begin : g_two
      logic             s1_valid_r;
      logic             s1_last_r;
      logic [127:0]     s1_data_r;
      logic [127:0]     s1_key_r;
      logic [TAG_W-1:0] s1_tag_r;

      // stage 1: ShiftRows(SubBytes) with its key, mode and tag; payload loads only on valid beats
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_data_r  <= 128'h0;
            s1_key_r   <= 128'h0;
            s1_tag_r   <= {TAG_W{1'b0}};
         end else if (adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
               s1_last_r <= in_last;
               s1_data_r <= shift_s;
               s1_key_r  <= in_key;
               s1_tag_r  <= in_tag;
            end
         end
      end

      assign mid_valid_s = s1_valid_r;
      assign mid_last_s  = s1_last_r;
      assign mid_data_s  = s1_data_r;
      assign mid_key_s   = s1_key_r;
      assign mid_tag_s   = s1_tag_r;
   end

   assign round_s = (mid_last_s ? mid_data_s : mix_columns(mid_data_s)) ^ mid_key_s;

   // output stage: bubbles clear valid but leave the last payload in place
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= 128'h0;
         out_tag_r   <= {TAG_W{1'b0}};
      end else if (adv_s) begin
         out_valid_r <= mid_valid_s;
         if (mid_valid_s) begin
            out_data_r <= round_s;
            out_tag_r  <= mid_tag_s;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_tag   = out_tag_r;
endmodule

// File: tb/tb_aes_round_pipe.sv
// Directed and randomised checks of aes_round_pipe with 2-stage and 1-stage instances
// driven in parallel, scored against an algebraic AES round model.

module tb_aes_round_pipe;
   localparam logic [127:0] VA_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
   localparam logic [127:0] VA_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] VA_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] VB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] VB_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] VB_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_last, out_ready;
   logic [127:0] in_data, in_key;
   logic [7:0]   in_tag;
   logic         d2_in_ready, d2_out_valid, d1_in_ready, d1_out_valid;
   logic [127:0] d2_out_data, d1_out_data;
   logic [7:0]   d2_out_tag, d1_out_tag;

   int n_checks = 0;
   int n_errors = 0;
   int n_out2 = 0, n_out1 = 0, n_in2 = 0;
   logic [135:0] q2[$];
   logic [135:0] q1[$];
   logic [135:0] hold2, hold1;
   logic         hold2_v = 1'b0, hold1_v = 1'b0;

   always #5 clk = ~clk;

   aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_last(in_last), .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
      .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data), .out_tag(d2_out_tag));

   aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready),
      .in_last(in_last), .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
      .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data), .out_tag(d1_out_tag));

   task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from the field inverse (a^254) followed by the affine map
   function automatic logic [7:0] ref_sbox(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                              input logic last);
      logic [7:0] s[16];
      logic [7:0] t[16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = ref_sbox(d[127 - 8*i -: 8]);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            t[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
            t[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
            t[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
         end
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = t[i];
      return res ^ k;
   endfunction

   // scoreboard for both instances: enqueue on input transfer, compare on output transfer
   always @(negedge clk) begin
      if (!rst_n) begin
         q2.delete();
         q1.delete();
         hold2_v = 1'b0;
         hold1_v = 1'b0;
      end else begin
         check("d2_ready_rule", 136'(d2_in_ready), 136'(!d2_out_valid | out_ready));
         check("d1_ready_rule", 136'(d1_in_ready), 136'(!d1_out_valid | out_ready));
         if (hold2_v) begin
            check("d2_stall_valid", 136'(d2_out_valid), 136'(1'b1));
            check("d2_stall_hold", {d2_out_data, d2_out_tag}, hold2);
         end
         if (hold1_v) begin
            check("d1_stall_valid", 136'(d1_out_valid), 136'(1'b1));
            check("d1_stall_hold", {d1_out_data, d1_out_tag}, hold1);
         end
         if (in_valid && d2_in_ready) begin
            q2.push_back({ref_round(in_data, in_key, in_last), in_tag});
            n_in2++;
         end
         if (in_valid && d1_in_ready) q1.push_back({ref_round(in_data, in_key, in_last), in_tag});
         if (d2_out_valid && out_ready) begin
            check("d2_expected_beat", 136'(q2.size() > 0), 136'(1'b1));
            if (q2.size() > 0) check("d2_beat", {d2_out_data, d2_out_tag}, q2.pop_front());
            n_out2++;
         end
         if (d1_out_valid && out_ready) begin
            check("d1_expected_beat", 136'(q1.size() > 0), 136'(1'b1));
            if (q1.size() > 0) check("d1_beat", {d1_out_data, d1_out_tag}, q1.pop_front());
            n_out1++;
         end
         hold2_v = d2_out_valid && !out_ready;
         hold2   = {d2_out_data, d2_out_tag};
         hold1_v = d1_out_valid && !out_ready;
         hold1   = {d1_out_data, d1_out_tag};
      end
   end

   task automatic present(input logic [127:0] d, input logic [127:0] k, input logic l,
                          input logic [7:0] t);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      in_key   = k;
      in_last  = l;
      in_tag   = t;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         idle();
         if (q2.size() == 0 && q1.size() == 0) break;
      end
      @(negedge clk);
      check("d2_drained", 136'(q2.size()), 136'(0));
      check("d1_drained", 136'(q1.size()), 136'(0));
   endtask

   initial begin
      int base2, base1, k, first, cyc;
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_data = 128'h0; in_key = 128'h0; in_tag = 8'h00;
      #12;
      check("rst_out_valid", 136'(d2_out_valid), 136'(1'b0));
      check("rst_out_payload", {d2_out_data, d2_out_tag}, 136'h0);
      check("rst_in_ready", 136'(d2_in_ready), 136'(1'b1));
      check("rst_d1_out_valid", 136'(d1_out_valid), 136'(1'b0));
      @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;

      // final round, latency 2 (d2) and 1 (d1)
      present(VA_IN, VA_KEY, 1'b1, 8'h5a);
      @(negedge clk); check("a_in_ready", 136'(d2_in_ready), 136'(1'b1));
      idle();
      @(negedge clk);
      check("a_d2_not_yet", 136'(d2_out_valid), 136'(1'b0));
      check("a_d1_valid", 136'(d1_out_valid), 136'(1'b1));
      check("a_d1_out", {d1_out_data, d1_out_tag}, {VA_OUT, 8'h5a});
      @(negedge clk);
      check("a_d2_valid", 136'(d2_out_valid), 136'(1'b1));
      check("a_d2_out", {d2_out_data, d2_out_tag}, {VA_OUT, 8'h5a});

      // normal round
      present(VB_IN, VB_KEY, 1'b0, 8'ha5);
      idle();
      @(negedge clk);
      check("b_d1_valid", 136'(d1_out_valid), 136'(1'b1));
      check("b_d1_out", 136'(d1_out_data), 136'(VB_OUT));
      check("b_d2_not_yet", 136'(d2_out_valid), 136'(1'b0));
      @(negedge clk);
      check("b_d2_valid", 136'(d2_out_valid), 136'(1'b1));
      check("b_d2_out", 136'(d2_out_data), 136'(VB_OUT));
      drain();

      // streaming: alternating vectors, one per cycle
      base2 = n_out2; base1 = n_out1;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) present(VA_IN, VA_KEY, 1'b1, 8'(i));
         else            present(VB_IN, VB_KEY, 1'b0, 8'(i));
         @(negedge clk);
         check("stream_in_ready", 136'(d2_in_ready), 136'(1'b1));
         if (i >= 2) check("stream_d2_valid", 136'(d2_out_valid), 136'(1'b1));
      end
      drain();
      check("stream_d2_count", 136'(n_out2 - base2), 136'(10));
      check("stream_d1_count", 136'(n_out1 - base1), 136'(10));

      // backpressure: 4 beats, 5 stalled cycles from the first output
      base2 = n_out2; k = 0; first = -1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (d2_out_valid && first < 0) first = c;
         out_ready = !(first >= 0 && c < first + 5);
         in_valid  = (k < 4);
         in_data   = k[0] ? VB_IN : VA_IN;
         in_key    = k[0] ? VB_KEY : VA_KEY;
         in_last   = !k[0];
         in_tag    = 8'(8'h10 + k);
         @(negedge clk);
         if (!out_ready) check("bp_in_ready", 136'(d2_in_ready), 136'(1'b0));
         if (in_valid && d2_in_ready) k++;
      end
      drain();
      check("bp_accepted", 136'(k), 136'(4));
      check("bp_d2_count", 136'(n_out2 - base2), 136'(4));

      // reset with two beats in flight
      present(VA_IN, VA_KEY, 1'b1, 8'h01);
      @(negedge clk);
      present(VB_IN, VB_KEY, 1'b0, 8'h02);
      @(negedge clk);
      @(posedge clk); #2;
      in_valid = 1'b0;
      check("pre_rst_d2_valid", 136'(d2_out_valid), 136'(1'b1));
      rst_n = 1'b0;
      #1;
      check("rst_d2_drop", 136'(d2_out_valid), 136'(1'b0));
      check("rst_d1_drop", 136'(d1_out_valid), 136'(1'b0));
      check("rst_mid_in_ready", 136'(d2_in_ready), 136'(1'b1));
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_d2_quiet", 136'(d2_out_valid), 136'(1'b0));
         check("post_rst_d1_quiet", 136'(d1_out_valid), 136'(1'b0));
      end

      // random traffic against the reference model
      base2 = n_in2; cyc = 0;
      while ((n_in2 - base2) < 1000 && cyc < 20000) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_key    = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_last   = 1'($urandom_range(0, 1));
         in_tag    = 8'($urandom_range(0, 255));
         cyc++;
      end
      check("rand_beats_done", 136'((n_in2 - base2) >= 1000), 136'(1'b1));
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
